// File: rtl/cache_line_mem_responder.sv
// Memory-side line responder for the direct-mapped data cache: fixed-latency fill/writeback of 4-word lines.
// Optional CACHE_MEM_ADDRCHK_EN: flag out-of-range word indices with rsp_err instead of wrapping.
module cache_line_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_write,
  output logic [127:0] rsp_rdata,
  output logic         rsp_err
);

  localparam int unsigned AW     = $clog2(MEM_WORDS);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (LATENCY == 0) ? CNT_W'(0) : CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          word_q, word_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [AW-1:0]       base_q, base_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [LINE_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [WORD_W-1:0]   mem [MEM_WORDS];
  logic [AW-1:0]       mem_idx;
  logic [WORD_W-1:0]   rd_word;
  logic [WORD_W-1:0]   wr_word;
  logic                mem_we;
  logic                addr_err_c;
  logic                unused_addr;

  // Range check on the incoming word index; without the check the index wraps.
`ifdef CACHE_MEM_ADDRCHK_EN
  assign addr_err_c = (req_addr[31:2] >> AW) != 30'd0;
`else
  assign addr_err_c = 1'b0;
`endif
  assign unused_addr = ^req_addr;

  assign mem_idx = base_q + AW'(word_q);
  assign rd_word = mem[mem_idx];
  assign wr_word = wdata_q[{word_q, 5'b0} +: WORD_W];
  assign mem_we  = (state_q == ST_XFER) && write_q && !err_q;

  // Backing array has no reset; a reset edge suppresses the write in flight.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_idx] <= wr_word;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    write_d     = write_q;
    err_d       = err_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    line_d      = line_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          err_d       = addr_err_c;
          base_d      = AW'({req_addr[31:4], 2'b00});
          wdata_d     = req_wdata;
          line_d      = '0;
          word_d      = 2'd0;
          req_ready_d = 1'b0;
          if (req_write) begin
            rsp_rdata_d = '0;
          end
          if (LATENCY == 0) begin
            state_d = ST_XFER;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_XFER: begin
        if (!write_q && !err_q) begin
          line_d[{word_q, 5'b0} +: WORD_W] = rd_word;
        end
        word_d = word_q + 2'd1;
        // Line buffer already holds zeros for writebacks and errored requests.
        if (word_q == 2'd3) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_err_d   = err_q;
          rsp_rdata_d = line_d;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      line_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      write_q     <= write_d;
      err_q       <= err_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      line_q      <= line_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
